// File: rtl/microwave_ctrl.sv
// rtl/microwave_ctrl.sv - microwave oven controller: keypad entry, cook countdown, pause, done beeper.
// Optional done beeper enabled by defining DONE_BEEP_EN.
module microwave_ctrl #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_loadn,
    output logic       timer_clrn,
    output logic       timer_en,
    output logic [3:0] timer_data,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        st;
    logic [PW-1:0] presc;
    logic [1:0]    digits;

    logic start_ok;
    logic key_ok;

    assign start_ok = start && door_closed && !timer_zero;
    assign key_ok   = key_valid && (key_data <= 4'd9) && (digits != 2'd3);
    assign state    = st;

`ifdef DONE_BEEP_EN
    localparam int unsigned BEEP_CYCLES = BEEP_TICKS * TICK_DIV;
    localparam int unsigned BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

    logic [BW-1:0] beep_cnt;
    logic          beep_r;

    assign beep = beep_r;
`else
    // Always 0 for legal BEEP_TICKS; the parameter only matters with the beeper built in.
    assign beep = (BEEP_TICKS < 1);
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st          <= S_IDLE;
            presc       <= '0;
            digits      <= '0;
            timer_loadn <= 1'b1;
            timer_clrn  <= 1'b1;
            timer_en    <= 1'b0;
            timer_data  <= 4'd0;
            mag_on      <= 1'b0;
`ifdef DONE_BEEP_EN
            beep_r      <= 1'b0;
            beep_cnt    <= '0;
`endif
        end else begin
            timer_loadn <= 1'b1;
            timer_clrn  <= 1'b1;
            timer_en    <= 1'b0;
            mag_on      <= 1'b0;

            case (st)
                S_IDLE, S_ENTRY: begin
                    if (stop) begin
                        timer_clrn <= 1'b0;
                        digits     <= '0;
                        st         <= S_IDLE;
                    end else if (start_ok && st == S_ENTRY) begin
                        st     <= S_COOK;
                        presc  <= '0;
                        mag_on <= 1'b1;
                    end else if (key_ok) begin
                        timer_loadn <= 1'b0;
                        timer_data  <= key_data;
                        digits      <= digits + 2'd1;
                        st          <= S_ENTRY;
                    end
                end

                S_COOK: begin
                    // Exit checks come before the tick so no enable leaks out on the leaving edge.
                    if (timer_zero) begin
                        st     <= S_DONE;
                        digits <= '0;
`ifdef DONE_BEEP_EN
                        beep_r   <= 1'b1;
                        beep_cnt <= '0;
`endif
                    end else if (!door_closed || stop) begin
                        st <= S_PAUSE;
                    end else begin
                        mag_on <= 1'b1;
                        if (presc == PRESC_LAST) begin
                            presc    <= '0;
                            timer_en <= 1'b1;
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                end

                S_PAUSE: begin
                    if (stop) begin
                        timer_clrn <= 1'b0;
                        digits     <= '0;
                        st         <= S_IDLE;
                    end else if (start_ok) begin
                        st     <= S_COOK;
                        presc  <= '0;
                        mag_on <= 1'b1;
                    end
                end

                S_DONE: begin
                    digits <= '0;
`ifdef DONE_BEEP_EN
                    if (stop || key_valid || beep_cnt == BEEP_LAST) begin
                        beep_r <= 1'b0;
                        st     <= S_IDLE;
                    end else begin
                        beep_cnt <= beep_cnt + BW'(1);
                    end
`else
                    st <= S_IDLE;
`endif
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_ctrl.sv
// tb/tb_microwave_ctrl.sv - self-checking bench for microwave_ctrl with TICK_DIV=4, BEEP_TICKS=2.
module tb_microwave_ctrl;

    localparam int TD = 4;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       clrn;
    logic       key_valid;
    logic [3:0] key_data;
    logic       start;
    logic       stop;
    logic       door_closed;
    logic       timer_zero;
    logic       timer_loadn;
    logic       timer_clrn;
    logic       timer_en;
    logic [3:0] timer_data;
    logic       mag_on;
    logic       beep;
    logic [2:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    int         mdl_cnt;
    logic [3:0] mdl_data;
    logic [2:0] mdl_state;

    microwave_ctrl #(.TICK_DIV(TD), .BEEP_TICKS(BT)) dut (
        .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_data(key_data),
        .start(start), .stop(stop), .door_closed(door_closed), .timer_zero(timer_zero),
        .timer_loadn(timer_loadn), .timer_clrn(timer_clrn), .timer_en(timer_en),
        .timer_data(timer_data), .mag_on(mag_on), .beep(beep), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_loadn"}, timer_loadn, 1);
        chk({tag, "_clrn"},  timer_clrn,  1);
        chk({tag, "_en"},    timer_en,    0);
        chk({tag, "_data"},  timer_data,  0);
        chk({tag, "_mag"},   mag_on,      0);
        chk({tag, "_beep"},  beep,        0);
        chk({tag, "_state"}, state,       0);
    endtask

    // Present one key, check the load pulse against the digit-entry rules, then an idle gap.
    task automatic key_step(input logic [3:0] k);
        bit acc;
        acc = (k <= 4'd9) && (mdl_cnt < 3);
        key_valid = 1'b1;
        key_data  = k;
        cyc();
        key_valid = 1'b0;
        if (acc) begin
            mdl_cnt++;
            mdl_data  = k;
            mdl_state = 3'd1;
        end
        chk("key_loadn", timer_loadn, acc ? 0 : 1);
        chk("key_data",  timer_data,  mdl_data);
        chk("key_state", state,       mdl_state);
        cyc();
        chk("key_gap_loadn", timer_loadn, 1);
    endtask

    task automatic start_cook();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("cook_state", state,    2);
        chk("cook_mag",   mag_on,   1);
        chk("cook_en0",   timer_en, 0);
    endtask

    // One enable every TD cycles, the first TD cycles after COOK is entered.
    task automatic cook_run(input int n);
        for (int k = 1; k <= n; k++) begin
            cyc();
            chk("cook_en",    timer_en, (k % TD == 0) ? 1 : 0);
            chk("cook_stay",  state,    2);
            chk("cook_mag_k", mag_on,   1);
        end
    endtask

    task automatic done_sequence();
        timer_zero = 1'b1;
        cyc();
        timer_zero = 1'b0;
        chk("done_state", state,      4);
        chk("done_mag",   mag_on,     0);
        chk("done_en",    timer_en,   0);
        chk("done_clrn",  timer_clrn, 1);
`ifdef DONE_BEEP_EN
        chk("done_beep0", beep, 1);
        for (int d = 1; d < BT * TD; d++) begin
            cyc();
            chk("done_beep_hold",  beep,  1);
            chk("done_state_hold", state, 4);
        end
        cyc();
        chk("done_beep_end",  beep,  0);
        chk("done_state_end", state, 0);
`else
        chk("done_beep0", beep, 0);
        cyc();
        chk("done_state_end", state, 0);
        chk("done_beep_end",  beep,  0);
`endif
        mdl_cnt   = 0;
        mdl_state = 3'd0;
    endtask

    initial begin
        clrn = 1'b0; key_valid = 1'b0; key_data = 4'd0; start = 1'b0;
        stop = 1'b0; door_closed = 1'b1; timer_zero = 1'b0;
        mdl_cnt = 0; mdl_data = 4'd0; mdl_state = 3'd0;

        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        clrn = 1'b1;
        cyc();
        chk("post_rst_state", state, 0);

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_idle_ignored", state, 0);

        key_step(4'(10 + $urandom_range(0, 5)));
        key_step(4'd1);
        key_step(4'd3);
        key_step(4'd0);
        key_step(4'd5);
        key_step(4'($urandom_range(0, 9)));

        // Door opens on the cycle that would otherwise raise an enable.
        start_cook();
        cook_run(TD * $urandom_range(1, 2) + TD - 1);
        door_closed = 1'b0;
        cyc();
        chk("pause_state", state,    3);
        chk("pause_mag",   mag_on,   0);
        chk("pause_en",    timer_en, 0);
        repeat (3) begin
            cyc();
            chk("pause_hold_en",    timer_en, 0);
            chk("pause_hold_state", state,    3);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("pause_open_start_state", state,  3);
        chk("pause_open_start_mag",   mag_on, 0);
        key_valid = 1'b1;
        key_data  = 4'd2;
        cyc();
        key_valid = 1'b0;
        chk("pause_key_loadn", timer_loadn, 1);
        chk("pause_key_state", state,       3);

        door_closed = 1'b1;
        start_cook();
        cook_run($urandom_range(5, 10));
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("cook_stop_state", state,      3);
        chk("cook_stop_clrn",  timer_clrn, 1);
        chk("cook_stop_mag",   mag_on,     0);

        start_cook();
        cook_run($urandom_range(2, 9));
        done_sequence();

        for (int i = 0; i < 5; i++) key_step(4'($urandom_range(0, 12)));
        key_step(4'($urandom_range(0, 9)));

        timer_zero = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        timer_zero = 1'b0;
        chk("start_zero_state", state,  1);
        chk("start_zero_mag",   mag_on, 0);

        start_cook();
        cook_run(3);
        door_closed = 1'b0;
        cyc();
        chk("pause2_state", state, 3);
        door_closed = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("cancel_clrn",  timer_clrn, 0);
        chk("cancel_state", state,      0);
        chk("cancel_mag",   mag_on,     0);
        cyc();
        chk("cancel_clrn_end", timer_clrn, 1);
        chk("cancel_idle",     state,      0);
        mdl_cnt = 0;
        mdl_state = 3'd0;

`ifdef DONE_BEEP_EN
        for (int i = 0; i < 3; i++) key_step(4'($urandom_range(0, 9)));
        start_cook();
        cook_run(2);
        timer_zero = 1'b1;
        cyc();
        timer_zero = 1'b0;
        chk("early_done_beep", beep, 1);
        cyc();
        chk("early_done_state", state, 4);
        key_valid = 1'b1;
        key_data  = 4'd7;
        cyc();
        key_valid = 1'b0;
        chk("early_end_state", state,       0);
        chk("early_end_beep",  beep,        0);
        chk("early_end_loadn", timer_loadn, 1);
        mdl_cnt = 0;
        mdl_state = 3'd0;
`endif

        key_step(4'd4);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("entry_stop_clrn",  timer_clrn, 0);
        chk("entry_stop_state", state,      0);
        mdl_cnt = 0;
        mdl_state = 3'd0;
        for (int i = 0; i < 3; i++) key_step(4'($urandom_range(0, 9)));
        key_step(4'd9);

        start_cook();
        cook_run(2);
        #3;
        clrn = 1'b0;
        #1;
        check_reset("async_rst");
        #1;
        clrn = 1'b1;
        cyc();
        chk("async_rst_idle", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
